// File: rtl/conv_sequencer.sv
// Sequencer for the 1-D convolution engine: loads filter taps, then per output point
// clears the accumulator, runs FILT_N MACs and writes the result through one memory port.
// Ports: clk, rst (sync, active-high), start, x/y/z base addresses in;
//        index, wrEn, filt_ld, tap_idx, mac_clr, mac_en, busy, done out.
module conv_sequencer #(
  parameter int LEN    = 9,
  parameter int FILT_N = 4,
  parameter int IN_N   = 16,
  localparam int OUT_N = IN_N - FILT_N + 1,
  localparam int IW    = (FILT_N > 1) ? $clog2(FILT_N) : 1,
  localparam int OW    = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [LEN-1:0] x,
  input  logic [LEN-1:0] y,
  input  logic [LEN-1:0] z,
  output logic [LEN-1:0] index,
  output logic           wrEn,
  output logic           filt_ld,
  output logic [IW-1:0]  tap_idx,
  output logic           mac_clr,
  output logic           mac_en,
  output logic           busy,
  output logic           done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLR, S_MAC, S_WRITE, S_DONE
  } state_t;

  localparam logic [IW-1:0] KMAX = IW'(FILT_N - 1);
  localparam logic [OW-1:0] IMAX = OW'(OUT_N - 1);

  state_t         state, state_n;
  logic [IW-1:0]  k, k_n;
  logic [IW-1:0]  j, j_n;
  logic [OW-1:0]  i, i_n;
  logic [LEN-1:0] xr, yr, zr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      k     <= '0;
      j     <= '0;
      i     <= '0;
      xr    <= '0;
      yr    <= '0;
      zr    <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      j     <= j_n;
      i     <= i_n;
      // Bases are captured only on an accepted start; later bus changes are ignored.
      if (state == S_IDLE && start) begin
        xr <= x;
        yr <= y;
        zr <= z;
      end
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    j_n     = j;
    i_n     = i;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          k_n     = '0;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (k == KMAX) begin
          i_n     = '0;
          state_n = S_CLR;
        end else begin
          k_n = k + 1'b1;
        end
      end
      S_CLR: begin
        j_n     = '0;
        state_n = S_MAC;
      end
      S_MAC: begin
        if (j == KMAX) state_n = S_WRITE;
        else           j_n     = j + 1'b1;
      end
      S_WRITE: begin
        if (i == IMAX) begin
          state_n = S_DONE;
        end else begin
          i_n     = i + 1'b1;
          state_n = S_CLR;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Address sums wrap modulo 2^LEN by truncation.
  always_comb begin
    index   = '0;
    wrEn    = 1'b0;
    filt_ld = 1'b0;
    tap_idx = '0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state)
      S_IDLE: busy = 1'b0;
      S_LOAD: begin
        index   = yr + LEN'(k);
        filt_ld = 1'b1;
        tap_idx = k;
      end
      S_CLR: mac_clr = 1'b1;
      S_MAC: begin
        index   = xr + LEN'(i) + LEN'(j);
        mac_en  = 1'b1;
        tap_idx = j;
      end
      S_WRITE: begin
        index = zr + LEN'(i);
        wrEn  = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: directed and random runs against a trace model
// built from the run order; a second instance covers the single-tap case.
module tb_conv_sequencer;

  logic       clk = 0;
  logic       rst = 1;
  logic       start = 0;
  logic       start2 = 0;
  logic [8:0] x = 0, y = 0, z = 0;

  logic [8:0] index;
  logic       wrEn, filt_ld, mac_clr, mac_en, busy, done;
  logic [1:0] tap_idx;

  logic [8:0] index2;
  logic       wr2, fl2, clr2, en2, busy2, done2;
  logic [0:0] tap2;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [8:0] idx;
    logic       wr;
    logic       fl;
    logic [1:0] tap;
    logic       clr;
    logic       en;
    logic       bsy;
    logic       dn;
  } obs_t;

  obs_t exp_q[$];

  always #5 clk = ~clk;

  conv_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .x(x), .y(y), .z(z),
    .index(index), .wrEn(wrEn), .filt_ld(filt_ld),
    .tap_idx(tap_idx), .mac_clr(mac_clr), .mac_en(mac_en),
    .busy(busy), .done(done)
  );

  conv_sequencer #(.LEN(9), .FILT_N(1), .IN_N(1)) dut1 (
    .clk(clk), .rst(rst), .start(start2),
    .x(x), .y(y), .z(z),
    .index(index2), .wrEn(wr2), .filt_ld(fl2),
    .tap_idx(tap2), .mac_clr(clr2), .mac_en(en2),
    .busy(busy2), .done(done2)
  );

  function automatic obs_t obs();
    return {index, wrEn, filt_ld, tap_idx, mac_clr, mac_en, busy, done};
  endfunction

  function automatic obs_t mk(logic [8:0] a, bit w, bit f, int t,
                              bit c, bit e, bit b, bit d);
    obs_t o;
    o.idx = a; o.wr = w; o.fl = f; o.tap = 2'(t);
    o.clr = c; o.en = e; o.bsy = b; o.dn = d;
    return o;
  endfunction

  // Expected per-cycle outputs for one run, cycle 1 .. done cycle.
  function automatic void gen(logic [8:0] xa, logic [8:0] ya, logic [8:0] za);
    exp_q.delete();
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk(ya + 9'(k), 0, 1, k, 0, 0, 1, 0));
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(mk(9'd0, 0, 0, 0, 1, 0, 1, 0));
      for (int j = 0; j < 4; j++)
        exp_q.push_back(mk(xa + 9'(i + j), 0, 0, j, 0, 1, 1, 0));
      exp_q.push_back(mk(za + 9'(i), 1, 0, 0, 0, 0, 1, 0));
    end
    exp_q.push_back(mk(9'd0, 0, 0, 0, 0, 0, 1, 1));
  endfunction

  task automatic chk(input string tag, input int cyc, input obs_t got, input obs_t want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run from start accept; optional re-pulse, abort-by-reset, or start hold.
  task automatic run(input logic [8:0] xa, input logic [8:0] ya, input logic [8:0] za,
                     input int repulse, input int abort, input bit hold);
    gen(xa, ya, za);
    if (exp_q.size() != 83) begin
      failures++;
      $display("FAIL model_len got=%0d want=83", exp_q.size());
    end
    x = xa; y = ya; z = za; start = 1;
    tick();
    for (int c = 1; c <= exp_q.size(); c++) begin
      start = hold;
      x = 9'($urandom); y = 9'($urandom); z = 9'($urandom);
      if (c == repulse) begin
        start = 1;
        x = 9'd50;
      end
      chk("seq", c, obs(), exp_q[c-1]);
      if (c == abort) begin
        rst = 1; start = 0;
        tick();
        rst = 0;
        chk("rst_mid", c + 1, obs(), '0);
        return;
      end
      tick();
    end
    chk("idle_after", exp_q.size() + 1, obs(), '0);
  endtask

  logic [15:0] exp1 [5];

  initial begin
    rst = 1;
    start = 1;
    tick();
    tick();
    chk("reset", 0, obs(), '0);
    rst = 0;
    start = 0;
    tick();
    chk("idle", 0, obs(), '0);

    run(9'd0, 9'd100, 9'd200, 0, 0, 0);
    run(9'd0, 9'd100, 9'd200, 10, 0, 0);
    run(9'd510, 9'd509, 9'd511, 0, 0, 0);
    run(9'd7, 9'd300, 9'd400, 0, 40, 0);
    run(9'd3, 9'd33, 9'd333, 0, 0, 0);
    run(9'd11, 9'd22, 9'd44, 0, 0, 1);
    run(9'd5, 9'd6, 9'd8, 0, 0, 0);
    for (int r = 0; r < 4; r++)
      run(9'($urandom), 9'($urandom), 9'($urandom), 0, 0, 0);

    // Reset coinciding with start wins.
    rst = 1; start = 1;
    tick();
    rst = 0; start = 0;
    chk("rst_vs_start", 0, obs(), '0);

    // Single-tap, single-input instance.
    x = 9'd70; y = 9'd80; z = 9'd90;
    exp1[0] = {9'd80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp1[1] = {9'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp1[2] = {9'd70, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp1[3] = {9'd90, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp1[4] = {9'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    start2 = 1;
    tick();
    start2 = 0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      assert ({index2, wr2, fl2, tap2, clr2, en2, busy2, done2} === exp1[c]) else begin
        failures++;
        $error("FAIL single_tap cyc=%0d got=%h want=%h", c + 1,
               {index2, wr2, fl2, tap2, clr2, en2, busy2, done2}, exp1[c]);
      end
      tick();
    end
    checks++;
    assert ({index2, wr2, fl2, tap2, clr2, en2, busy2, done2} === 16'd0) else begin
      failures++;
      $error("FAIL single_tap_idle got=%h want=0",
             {index2, wr2, fl2, tap2, clr2, en2, busy2, done2});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
